// File: rtl/alarm_ctrl_12hr.sv
// alarm_ctrl_12hr
// ---------------------------------------------------------------------------
// Alarm controller for a 12-hour h/m/s/ms timekeeper running on the same
// 1 kHz clock (one clk_i cycle = 1 ms). It holds a base alarm time and an
// active target (base or snoozed), detects the minute boundary that equals
// the active target, runs an IDLE/ARMED/RINGING/SNOOZE state machine and
// drives a gated square wave for the buzzer.
//
// Optional build macro: SNOOZE_LIMIT_EN
//   defined   - at most three accepted snoozes per ringing episode; the
//               count clears on stop, timeout, valid load, arm_i=0, reset.
//   undefined - unlimited snoozes.
//
// Ports:
//   clk_i          in   1  clock, 1 kHz
//   reset_i        in   1  synchronous reset, active-high
//   hour_i         in   5  current hour 1..12
//   min_i          in   6  current minute 0..59
//   sec_i          in   6  current second 0..59
//   ms_i           in  10  current millisecond 0..999
//   alarm_hour_i   in   5  alarm hour to load (1..12)
//   alarm_min_i    in   6  alarm minute to load (0..59)
//   alarm_load_i   in   1  strobe: capture alarm_hour_i/alarm_min_i
//   arm_i          in   1  level: alarm enabled
//   snooze_i       in   1  strobe: snooze
//   stop_i         in   1  strobe: stop ringing
//   alarm_hour_o   out  5  active target hour
//   alarm_min_o    out  6  active target minute
//   match_o        out  1  pulse: current time reached the active target
//   ringing_o      out  1  high while RINGING
//   snoozed_o      out  1  high while SNOOZE
//   beep_o         out  1  buzzer square wave, 0 unless RINGING
//   load_err_o     out  1  pulse: a load was rejected
//
// Handshake: there is no valid/ready flow control here. alarm_load_i,
// snooze_i and stop_i are single-cycle strobes consumed in the cycle they
// are high; a strobe that has no meaning in the current state is dropped.
// ---------------------------------------------------------------------------
module alarm_ctrl_12hr #(
   parameter int unsigned SNOOZE_MIN       = 9,
   parameter int unsigned RING_TIMEOUT_SEC = 60,
   parameter int unsigned BEEP_HALF_MS     = 250
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [4:0] hour_i,
   input  logic [5:0] min_i,
   input  logic [5:0] sec_i,
   input  logic [9:0] ms_i,
   input  logic [4:0] alarm_hour_i,
   input  logic [5:0] alarm_min_i,
   input  logic       alarm_load_i,
   input  logic       arm_i,
   input  logic       snooze_i,
   input  logic       stop_i,
   output logic [4:0] alarm_hour_o,
   output logic [5:0] alarm_min_o,
   output logic       match_o,
   output logic       ringing_o,
   output logic       snoozed_o,
   output logic       beep_o,
   output logic       load_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(RING_TIMEOUT_SEC * 1000 - 1);
   localparam logic [9:0]  BEEP_LAST    = 10'(BEEP_HALF_MS - 1);
   localparam logic [6:0]  SNOOZE_ADD   = 7'(SNOOZE_MIN);

   state_t     state_q, state_d;
   logic [4:0] base_hour_q, act_hour_q;
   logic [5:0] base_min_q, act_min_q;
   logic [15:0] tmo_q, tmo_d;
   logic [9:0] beep_cnt_q, beep_cnt_d;
   logic       beep_q, beep_d;
   logic       match_q;
   logic       load_err_q;

   logic       load_valid, load_ok, load_bad;
   logic       match_now, timeout_hit, snooze_ok;
   logic       restore_tgt, snooze_tgt;
   logic [6:0] min_sum;
   logic [4:0] snz_hour;
   logic [5:0] snz_min;

   // ---------------- condition decode ----------------
   assign load_valid  = (alarm_hour_i >= 5'd1) && (alarm_hour_i <= 5'd12) &&
                        (alarm_min_i <= 6'd59);
   assign load_ok     = alarm_load_i & load_valid;
   assign load_bad    = alarm_load_i & ~load_valid;
   assign match_now   = (hour_i == act_hour_q) && (min_i == act_min_q) &&
                        (sec_i == 6'd0) && (ms_i == 10'd0);
   assign timeout_hit = (tmo_q == TIMEOUT_LAST);

`ifdef SNOOZE_LIMIT_EN
   logic [1:0] snz_cnt_q;
   logic       snz_clr, snz_inc;

   assign snooze_ok = snooze_i && (snz_cnt_q != 2'd3);
   // Every path out of RINGING/SNOOZE back to ARMED is a stop, a timeout or
   // a load, so one test on the transition covers all of them.
   assign snz_clr   = !arm_i || load_ok ||
                      (((state_q == ST_RINGING) || (state_q == ST_SNOOZE)) &&
                       (state_d == ST_ARMED));
   assign snz_inc   = (state_q == ST_RINGING) && (state_d == ST_SNOOZE);

   always_ff @(posedge clk_i) begin
      if (reset_i || snz_clr) snz_cnt_q <= 2'd0;
      else if (snz_inc)       snz_cnt_q <= snz_cnt_q + 2'd1;
   end
`else
   assign snooze_ok = snooze_i;
`endif

   // Snoozed target: minute wraps past 59 and the hour runs 12 -> 1.
   always_comb begin
      min_sum  = {1'b0, act_min_q} + SNOOZE_ADD;
      snz_hour = act_hour_q;
      snz_min  = min_sum[5:0];
      if (min_sum >= 7'd60) begin
         snz_min  = 6'(min_sum - 7'd60);
         snz_hour = (act_hour_q == 5'd12) ? 5'd1 : act_hour_q + 5'd1;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // Priority: arm_i low > load > stop > snooze > match/timeout.
   always_comb begin
      state_d     = state_q;
      restore_tgt = 1'b0;
      snooze_tgt  = 1'b0;
      if (!arm_i) begin
         state_d     = ST_IDLE;
         restore_tgt = 1'b1;
      end else if (alarm_load_i) begin
         // A rejected load leaves everything as it was this cycle.
         if (load_valid) state_d = ST_ARMED;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_ARMED;
            ST_ARMED: if (match_now) state_d = ST_RINGING;
            ST_RINGING: begin
               if (stop_i) begin
                  state_d     = ST_ARMED;
                  restore_tgt = 1'b1;
               end else if (snooze_ok) begin
                  state_d    = ST_SNOOZE;
                  snooze_tgt = 1'b1;
               end else if (timeout_hit) begin
                  state_d     = ST_ARMED;
                  restore_tgt = 1'b1;
               end
            end
            ST_SNOOZE: begin
               if (stop_i) begin
                  state_d     = ST_ARMED;
                  restore_tgt = 1'b1;
               end else if (match_now) begin
                  state_d = ST_RINGING;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ringing_o    = (state_q == ST_RINGING);
      snoozed_o    = (state_q == ST_SNOOZE);
      beep_o       = beep_q;
      match_o      = match_q;
      load_err_o   = load_err_q;
      alarm_hour_o = act_hour_q;
      alarm_min_o  = act_min_q;
   end

   // ---------------- ring timer and beep generator ----------------
   always_comb begin
      tmo_d      = 16'd0;
      beep_cnt_d = 10'd0;
      beep_d     = 1'b0;
      if (state_d == ST_RINGING) begin
         if (state_q != ST_RINGING) begin
            // Fresh ring: start the tone high with a full half-period.
            beep_d = 1'b1;
         end else begin
            tmo_d = tmo_q + 16'd1;
            if (beep_cnt_q == BEEP_LAST) begin
               beep_d = ~beep_q;
            end else begin
               beep_cnt_d = beep_cnt_q + 10'd1;
               beep_d     = beep_q;
            end
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         base_hour_q <= 5'd12;
         base_min_q  <= 6'd0;
         act_hour_q  <= 5'd12;
         act_min_q   <= 6'd0;
         tmo_q       <= 16'd0;
         beep_cnt_q  <= 10'd0;
         beep_q      <= 1'b0;
         match_q     <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         tmo_q      <= tmo_d;
         beep_cnt_q <= beep_cnt_d;
         beep_q     <= beep_d;
         match_q    <= match_now;
         load_err_q <= load_bad;
         // A valid load beats the restore done on disarm.
         if (load_ok) begin
            base_hour_q <= alarm_hour_i;
            base_min_q  <= alarm_min_i;
            act_hour_q  <= alarm_hour_i;
            act_min_q   <= alarm_min_i;
         end else if (restore_tgt) begin
            act_hour_q <= base_hour_q;
            act_min_q  <= base_min_q;
         end else if (snooze_tgt) begin
            act_hour_q <= snz_hour;
            act_min_q  <= snz_min;
         end
      end
   end

endmodule

// File: tb/tb_alarm_ctrl_12hr.sv
// Directed testbench for alarm_ctrl_12hr with hand-computed expectations.
module tb_alarm_ctrl_12hr;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic       reset_i;
   logic [4:0] hour_i;
   logic [5:0] min_i;
   logic [5:0] sec_i;
   logic [9:0] ms_i;
   logic [4:0] alarm_hour_i;
   logic [5:0] alarm_min_i;
   logic       alarm_load_i;
   logic       arm_i;
   logic       snooze_i;
   logic       stop_i;
   logic [4:0] alarm_hour_o;
   logic [5:0] alarm_min_o;
   logic       match_o;
   logic       ringing_o;
   logic       snoozed_o;
   logic       beep_o;
   logic       load_err_o;

   alarm_ctrl_12hr dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .hour_i       (hour_i),
      .min_i        (min_i),
      .sec_i        (sec_i),
      .ms_i         (ms_i),
      .alarm_hour_i (alarm_hour_i),
      .alarm_min_i  (alarm_min_i),
      .alarm_load_i (alarm_load_i),
      .arm_i        (arm_i),
      .snooze_i     (snooze_i),
      .stop_i       (stop_i),
      .alarm_hour_o (alarm_hour_o),
      .alarm_min_o  (alarm_min_o),
      .match_o      (match_o),
      .ringing_o    (ringing_o),
      .snoozed_o    (snoozed_o),
      .beep_o       (beep_o),
      .load_err_o   (load_err_o)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 ns after the rising edge; outputs are sampled there too.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic set_time(input int h, input int m, input int s, input int ms);
      hour_i = 5'(h);
      min_i  = 6'(m);
      sec_i  = 6'(s);
      ms_i   = 10'(ms);
   endtask

   task automatic do_load(input int h, input int m);
      alarm_hour_i = 5'(h);
      alarm_min_i  = 6'(m);
      alarm_load_i = 1'b1;
      tick(1);
      alarm_load_i = 1'b0;
   endtask

   task automatic do_snooze();
      snooze_i = 1'b1;
      tick(1);
      snooze_i = 1'b0;
   endtask

   task automatic do_stop();
      stop_i = 1'b1;
      tick(1);
      stop_i = 1'b0;
   endtask

   // Present the exact minute boundary for one cycle, then move 1 ms on.
   task automatic ring_at(input int h, input int m);
      set_time(h, m, 0, 0);
      tick(1);
      set_time(h, m, 0, 1);
   endtask

   task automatic check_target(input string tag, input int h, input int m);
      check_eq({tag, "_hour"}, alarm_hour_o, h);
      check_eq({tag, "_min"},  alarm_min_o,  m);
   endtask

   task automatic check_status(input string tag, input int ring, input int snz, input int beep);
      check_eq({tag, "_ringing"}, ringing_o, ring);
      check_eq({tag, "_snoozed"}, snoozed_o, snz);
      check_eq({tag, "_beep"},    beep_o,    beep);
   endtask

`ifdef SNOOZE_LIMIT_EN
   int lim_h[3] = '{7, 7, 7};
   int lim_m[3] = '{39, 48, 57};
`endif

   // ---------------- stimulus ----------------
   initial begin
      reset_i      = 1'b1;
      arm_i        = 1'b0;
      alarm_load_i = 1'b0;
      alarm_hour_i = 5'd1;
      alarm_min_i  = 6'd0;
      snooze_i     = 1'b0;
      stop_i       = 1'b0;
      set_time(1, 0, 30, 500);

      // Reset state
      tick(2);
      check_target("rst", 12, 0);
      check_status("rst", 0, 0, 0);
      check_eq("rst_match", match_o, 0);
      check_eq("rst_load_err", load_err_o, 0);
      reset_i = 1'b0;

      // 1: arm, load 7:30, ring, beep cadence
      arm_i = 1'b1;
      tick(1);
      do_load(7, 30);
      check_target("load730", 7, 30);
      check_eq("load730_err", load_err_o, 0);
      ring_at(7, 30);
      check_eq("t1_match_hi", match_o, 1);
      check_status("t1_ring", 1, 0, 1);
      tick(1);
      check_eq("t1_match_lo", match_o, 0);
      tick(248);
      check_eq("t1_beep_249", beep_o, 1);
      tick(1);
      check_eq("t1_beep_250", beep_o, 0);
      tick(249);
      check_eq("t1_beep_499", beep_o, 0);
      tick(1);
      check_eq("t1_beep_500", beep_o, 1);

      // 2: snooze to 7:39, ring again, stop back to 7:30
      do_snooze();
      check_status("t2_snz", 0, 1, 0);
      check_target("t2_snz", 7, 39);
      ring_at(7, 39);
      check_eq("t2_match", match_o, 1);
      check_status("t2_ring", 1, 0, 1);
      do_stop();
      check_status("t2_stop", 0, 0, 0);
      check_target("t2_stop", 7, 30);

      // 3: hour wrap 12:55+9 -> 1:04, 11:55+9 -> 12:04
      do_load(12, 55);
      check_target("load1255", 12, 55);
      ring_at(12, 55);
      check_eq("t3_ring1255", ringing_o, 1);
      do_snooze();
      check_target("t3_snz104", 1, 4);
      do_load(11, 55);
      check_status("t3_load_in_snz", 0, 0, 0);
      check_target("load1155", 11, 55);
      ring_at(11, 55);
      check_eq("t3_ring1155", ringing_o, 1);
      do_snooze();
      check_target("t3_snz1204", 12, 4);
      do_stop();
      check_target("t3_stop", 11, 55);

      // 4: unattended ring times out after exactly 60000 cycles
      ring_at(11, 55);
      check_status("t4_start", 1, 0, 1);
      tick(59999);
      check_status("t4_last", 1, 0, 0);
      tick(1);
      check_status("t4_timeout", 0, 0, 0);
      check_target("t4_timeout", 11, 55);
      ring_at(11, 55);
      check_eq("t4_rearmed", ringing_o, 1);

      // 5: stop beats snooze; rejected loads
      stop_i   = 1'b1;
      snooze_i = 1'b1;
      tick(1);
      stop_i   = 1'b0;
      snooze_i = 1'b0;
      check_status("t5_stop_wins", 0, 0, 0);
      check_target("t5_stop_wins", 11, 55);
      do_load(13, 0);
      check_eq("t5_err_13", load_err_o, 1);
      check_target("t5_err_13", 11, 55);
      tick(1);
      check_eq("t5_err_pulse", load_err_o, 0);
      do_load(5, 60);
      check_eq("t5_err_560", load_err_o, 1);
      check_target("t5_err_560", 11, 55);
      do_load(0, 10);
      check_eq("t5_err_0", load_err_o, 1);
      check_target("t5_err_0", 11, 55);

      // 6: disarm mid-ring and mid-snooze
      ring_at(11, 55);
      check_eq("t6_ring", ringing_o, 1);
      arm_i = 1'b0;
      tick(1);
      check_status("t6_disarm_ring", 0, 0, 0);
      ring_at(11, 55);
      check_eq("t6_idle_match", match_o, 1);
      check_eq("t6_idle_noring", ringing_o, 0);
      arm_i = 1'b1;
      tick(1);
      ring_at(11, 55);
      do_snooze();
      check_status("t6_snz", 0, 1, 0);
      check_target("t6_snz", 12, 4);
      arm_i = 1'b0;
      tick(1);
      check_status("t6_disarm_snz", 0, 0, 0);
      check_target("t6_disarm_snz", 11, 55);

`ifdef SNOOZE_LIMIT_EN
      arm_i = 1'b1;
      tick(1);
      do_load(7, 30);
      ring_at(7, 30);
      check_eq("lim_ring0", ringing_o, 1);
      for (int k = 0; k < 3; k++) begin
         do_snooze();
         check_eq("lim_snz", snoozed_o, 1);
         check_target("lim_snz", lim_h[k], lim_m[k]);
         ring_at(lim_h[k], lim_m[k]);
         check_eq("lim_ring", ringing_o, 1);
      end
      do_snooze();
      check_status("lim_4th", 1, 0, beep_o);
      check_eq("lim_4th_ringing", ringing_o, 1);
      check_target("lim_4th", 7, 57);
`endif

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
